// File: rtl/led_ram_readback_pkg.sv
// Shared state encoding and widths for the program-RAM read-back viewer.
// Optional build macro: LED_READBACK_CHECKSUM_EN.
package led_ram_readback_pkg;
   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      LATCH,
      SHOW,
      DONE
   } state_e;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 8;
   localparam logic [ADDR_W-1:0] LAST_ADDR = 8'hFF;
   localparam logic [DATA_W-1:0] TERM_BYTE = 8'h00;
endpackage

// File: rtl/led_ram_readback_enter_debounce.sv
// Debounce filter for the enter button; a level change is taken only
// after NDELAY consecutive stable cycles (NDELAY=0 passes through).
module enter_debounce
   import led_ram_readback_pkg::*;
#(
   parameter int NDELAY = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic out
);

   if (NDELAY == 0) begin : g_pass
      logic unused_ok;
      assign unused_ok = clk ^ rst;
      assign out = in;
   end else begin : g_filt
      localparam logic [31:0] LIM = 32'(NDELAY - 1);
      logic        out_q;
      logic [31:0] cnt_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            out_q <= 1'b0;
            cnt_q <= '0;
         end else if (in == out_q) begin
            cnt_q <= '0;
         end else if (cnt_q == LIM) begin
            out_q <= in;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 32'd1;
         end
      end

      assign out = out_q;
   end

endmodule

// File: rtl/led_ram_readback.sv
// Walks the LED program RAM from address 0, one byte per step, until a
// 00,00 pair ends on an odd address or address 255 is passed.
// Optional build macro: LED_READBACK_CHECKSUM_EN (show byte sum in DONE).
module led_ram_readback
   import led_ram_readback_pkg::*;
#(
   parameter int NDELAY = 0,
   parameter int FREQ   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              enter,
   output logic [ADDR_W-1:0] rdAddr,
   input  logic [DATA_W-1:0] rdData,
   output logic [DATA_W-1:0] outPattern,
   output logic [ADDR_W-1:0] addrOut,
   output logic              busy,
   output logic              done
);

   localparam logic [31:0] FREQ_C = 32'(FREQ);
   localparam bit          AUTO   = (FREQ != 0);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   pat_q, pat_d;
   logic [ADDR_W-1:0]   aout_q, aout_d;
   logic [DATA_W-1:0]   prev_q, prev_d;
   logic [31:0]         timer_q, timer_d;
   logic                en_db, en_q;
   logic                step;
`ifdef LED_READBACK_CHECKSUM_EN
   logic [DATA_W-1:0]   sum_q, sum_d;
`endif

   enter_debounce #(
      .NDELAY(NDELAY)
   ) u_db (
      .clk(clk),
      .rst(rst),
      .in (enter),
      .out(en_db)
   );

   assign step = (en_db & ~en_q) | (AUTO && (timer_q == FREQ_C));

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      pat_d   = pat_q;
      aout_d  = aout_q;
      prev_d  = prev_q;
      timer_d = timer_q;
`ifdef LED_READBACK_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = WAIT;
               addr_d  = '0;
               prev_d  = 8'hFF;
               timer_d = '0;
`ifdef LED_READBACK_CHECKSUM_EN
               sum_d   = '0;
`endif
            end
         end
         WAIT: state_d = LATCH;
         LATCH: begin
            pat_d  = rdData;
            aout_d = addr_q;
`ifdef LED_READBACK_CHECKSUM_EN
            sum_d  = sum_q + rdData;
`endif
            // terminator pair must end on an odd address
            if (addr_q[0] && rdData == TERM_BYTE &&
                prev_q == TERM_BYTE) begin
               state_d = DONE;
`ifdef LED_READBACK_CHECKSUM_EN
               pat_d   = sum_q + rdData;
`endif
            end else begin
               prev_d  = rdData;
               state_d = SHOW;
            end
         end
         SHOW: begin
            if (step) begin
               if (addr_q == LAST_ADDR) begin
                  state_d = DONE;
`ifdef LED_READBACK_CHECKSUM_EN
                  pat_d   = sum_q;
`endif
               end else begin
                  addr_d  = addr_q + 8'd1;
                  timer_d = '0;
                  state_d = WAIT;
               end
            end else if (AUTO) begin
               timer_d = timer_q + 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         pat_q   <= '0;
         aout_q  <= '0;
         prev_q  <= 8'hFF;
         timer_q <= '0;
         en_q    <= 1'b0;
`ifdef LED_READBACK_CHECKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         pat_q   <= pat_d;
         aout_q  <= aout_d;
         prev_q  <= prev_d;
         timer_q <= timer_d;
         en_q    <= en_db;
`ifdef LED_READBACK_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

   assign rdAddr     = addr_q;
   assign outPattern = pat_q;
   assign addrOut    = aout_q;
   assign busy       = (state_q == WAIT) || (state_q == LATCH) ||
                       (state_q == SHOW);
   assign done       = (state_q == DONE);

endmodule

// File: tb/tb_led_ram_readback.sv
// Bench for led_ram_readback: manual/debounced walker checked every cycle
// against a transaction model, plus an auto-stepping walker.
module tb_led_ram_readback;

   localparam int ND = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   // manual instance
   logic       rst1, start1, enter1, busy1, done1;
   logic [7:0] ra1, rd1, pat1, aout1;
   logic [7:0] mem1 [256];

   // auto-step instance
   logic       rst2, start2, enter2, busy2, done2;
   logic [7:0] ra2, rd2, pat2, aout2;
   logic [7:0] mem2 [256];

   always @(posedge clk) rd1 <= mem1[ra1];
   always @(posedge clk) rd2 <= mem2[ra2];

   led_ram_readback #(.NDELAY(ND), .FREQ(0)) u1 (
      .clk(clk), .rst(rst1), .start(start1), .enter(enter1),
      .rdAddr(ra1), .rdData(rd1), .outPattern(pat1),
      .addrOut(aout1), .busy(busy1), .done(done1)
   );

   led_ram_readback #(.NDELAY(0), .FREQ(4)) u2 (
      .clk(clk), .rst(rst2), .start(start2), .enter(enter2),
      .rdAddr(ra2), .rdData(rd2), .outPattern(pat2),
      .addrOut(aout2), .busy(busy2), .done(done2)
   );

   task automatic chk(string nm, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // ---------------- walk model for u1 ----------------
   typedef struct {
      int         c;
      logic [7:0] pat;
      logic [7:0] aout;
      logic [7:0] ra;
      logic       busy;
      logic       done;
   } ev_t;

   ev_t        q[$];
   ev_t        L;
   ev_t        X;
   bit         m_walk = 0;
   logic [7:0] m_idx, m_prev, m_sum;

   function automatic ev_t rst_ev();
      ev_t e;
      e.c = 0; e.pat = 0; e.aout = 0; e.ra = 0;
      e.busy = 0; e.done = 0;
      return e;
   endfunction

   function automatic int pk(ev_t e);
      return {6'd0, e.pat, e.aout, e.ra, e.busy, e.done};
   endfunction

   task automatic push(int k);
      ev_t e;
      e = L;
      e.c = k;
      q.push_back(e);
   endtask

   task automatic m_latch(int k);
      logic [7:0] b;
      b = mem1[m_idx];
      m_sum = m_sum + b;
      L.aout = m_idx;
      if (m_idx[0] && b == 8'h00 && m_prev == 8'h00) begin
`ifdef LED_READBACK_CHECKSUM_EN
         L.pat = m_sum;
`else
         L.pat = b;
`endif
         L.busy = 0;
         L.done = 1;
         m_walk = 0;
      end else begin
         L.pat = b;
         m_prev = b;
      end
      push(k);
   endtask

   task automatic m_start(int n);
      if (m_walk) return;
      m_walk = 1;
      m_idx = 0;
      m_prev = 8'hFF;
      m_sum = 0;
      L.ra = 0;
      L.busy = 1;
      L.done = 0;
      push(n);
      m_latch(n + 2);
   endtask

   task automatic m_step(int m);
      if (!m_walk) return;
      if (m_idx == 8'hFF) begin
         L.busy = 0;
         L.done = 1;
         m_walk = 0;
`ifdef LED_READBACK_CHECKSUM_EN
         L.pat = m_sum;
`endif
         push(m);
      end else begin
         m_idx = m_idx + 8'd1;
         L.ra = m_idx;
         push(m);
         m_latch(m + 2);
      end
   endtask

   // compare process for u1, every cycle
   initial begin
      X = rst_ev();
      forever begin
         @(posedge clk);
         #1;
         while (q.size() > 0 && q[0].c <= cyc) X = q.pop_front();
         chk("u1 {pat,aout,ra,busy,done}",
             {6'd0, pat1, aout1, ra1, busy1, done1}, pk(X));
      end
   end

   // ---------------- stimulus helpers (entered at negedge) -------------
   task automatic start1_t();
      m_start(cyc + 1);
      start1 = 1;
      @(negedge clk);
      start1 = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic press1(int h, bit sw);
      bit swk;
      swk = sw && m_walk;
      m_step(cyc + 1 + ND);
      for (int i = 0; i < h; i++) begin
         enter1 = 1;
         start1 = swk && (i == ND);
         @(negedge clk);
      end
      enter1 = 0;
      start1 = 0;
      repeat (ND + 2) @(negedge clk);
   endtask

   task automatic rst1_t();
      q.delete();
      m_walk = 0;
      L = rst_ev();
      push(cyc + 1);
      rst1 = 1;
      @(posedge clk);
      #1;
      chk("rst mid pat", pat1, 0);
      chk("rst mid addrOut", aout1, 0);
      chk("rst mid busy", busy1, 0);
      @(negedge clk);
      rst1 = 0;
   endtask

   task automatic wait_neg(int c);
      while (cyc < c) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] prog [8];
      logic [7:0] fin2;
      int n2, g;
      L = rst_ev();
      rst1 = 1; start1 = 0; enter1 = 0;
      rst2 = 1; start2 = 0; enter2 = 0;
      for (int i = 0; i < 256; i++) begin
         mem1[i] = 8'h00;
         mem2[i] = 8'h00;
      end
      repeat (3) @(negedge clk);
      rst1 = 0;
      rst2 = 0;
      chk("reset pat", pat1, 8'h00);
      chk("reset addrOut", aout1, 8'h00);
      chk("reset rdAddr", ra1, 8'h00);
      chk("reset busy", busy1, 0);
      chk("reset done", done1, 0);

      // fixed program
      prog = '{8'hAA, 8'h01, 8'h88, 8'h03, 8'hF0, 8'h02, 8'h00, 8'h00};
      for (int i = 0; i < 8; i++) mem1[i] = prog[i];
      for (int i = 8; i < 256; i++) mem1[i] = 8'h55;
      start1_t();
      chk("prog a0 pat", pat1, 8'hAA);
      chk("prog a0 busy", busy1, 1);
      press1(ND + 1, 0);
      press1(ND + 1, 0);
      // short glitch must be filtered out
      enter1 = 1;
      repeat (2) @(negedge clk);
      enter1 = 0;
      repeat (6) @(negedge clk);
      chk("glitch addrOut", aout1, 2);
      chk("glitch pat", pat1, 8'h88);
      press1(4, 0);
      chk("press4 addrOut", aout1, 3);
      chk("press4 pat", pat1, 8'h03);
      repeat (4) press1(ND + 1, 0);
      chk("prog done", done1, 1);
      chk("prog end addrOut", aout1, 7);
`ifdef LED_READBACK_CHECKSUM_EN
      chk("prog end pat", pat1, 8'h28);
`else
      chk("prog end pat", pat1, 8'h00);
`endif
      press1(ND + 1, 0);
      chk("press in DONE", aout1, 7);

      // reset mid-walk, then restart
      start1_t();
      repeat (3) press1(ND + 1, 0);
      chk("pre-rst addrOut", aout1, 3);
      rst1_t();
      start1_t();
      chk("restart addrOut", aout1, 0);
      chk("restart pat", pat1, 8'hAA);
      repeat (3) press1(ND + 1, 0);
      rst1_t();

      // random programs; the last one has no terminator
      for (int p = 0; p < 6; p++) begin
         for (int i = 0; i < 256; i++) begin
            if (p < 5 && $urandom_range(0, 3) == 0) mem1[i] = 8'h00;
            else mem1[i] = 8'($urandom_range(1, 255));
         end
         start1_t();
         g = 0;
         while (m_walk && g < 300) begin
            press1(ND + 1 + $urandom_range(0, 3),
                   $urandom_range(0, 3) == 0);
            if (m_walk && $urandom_range(0, 4) == 0) begin
               start1 = 1;
               @(negedge clk);
               start1 = 0;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            g++;
         end
         chk("walk ended", int'(m_walk), 0);
      end
      repeat (3) @(negedge clk);

      // auto-step walker: FREQ+3 = 7 cycles per byte
      fin2 = 0;
      for (int i = 0; i < 256; i++) begin
         mem2[i] = 8'($urandom_range(1, 255));
         fin2 = fin2 + mem2[i];
      end
`ifndef LED_READBACK_CHECKSUM_EN
      fin2 = mem2[255];
`endif
      n2 = cyc + 1;
      start2 = 1;
      @(negedge clk);
      start2 = 0;
      fork
         begin
            for (int t = 0; t < 1800; t++) begin
               int k;
               int ea, er;
               @(posedge clk);
               #1;
               k = cyc - n2;
               if (k >= 1792) begin
                  chk("auto done", done2, 1);
                  chk("auto busy", busy2, 0);
                  chk("auto addrOut", aout2, 255);
                  chk("auto rdAddr", ra2, 255);
                  chk("auto pat", pat2, fin2);
               end else begin
                  er = k / 7;
                  ea = (k >= 2) ? (k - 2) / 7 : 0;
                  chk("auto done", done2, 0);
                  chk("auto busy", busy2, 1);
                  chk("auto rdAddr", ra2, er);
                  chk("auto addrOut", aout2, ea);
                  chk("auto pat", pat2, (k >= 2) ? mem2[ea] : 0);
               end
            end
         end
         begin
            for (int i = 0; i < 40; i++) begin
               int m;
               m = n2 + 7 * (i + 1);
               case ($urandom_range(0, 2))
                  1: begin
                     wait_neg(m);
                     enter2 = 1;
                     repeat (2) @(negedge clk);
                     enter2 = 0;
                  end
                  2: begin
                     wait_neg(m + 2 + $urandom_range(0, 4));
                     start2 = 1;
                     @(negedge clk);
                     start2 = 0;
                  end
                  default: ;
               endcase
            end
         end
      join
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
